// File: rtl/eth_tx_arb_pkg.sv
// Shared types and constants for the 10G MAC TX-path arbiter.
package eth_tx_arb_pkg;

   localparam int AXIS_DATA_W   = 64;
   localparam int AXIS_KEEP_W   = 8;
   localparam int MAX_BEATS_DEF = 190;  // 190 x 8 B = 1520 B

   typedef enum logic [1:0] {
      IDLE,
      PASS,
      DRAIN
   } arb_state_t;

endpackage

// File: rtl/eth_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from last_grant+1, wrapping.
// With prio0 set, requester 0 wins outright and 1..N_SRC-1 rotate among themselves.
module rr_pick #(
   parameter int N_SRC = 2
) (
   input  logic [N_SRC-1:0]         req,
   input  logic [$clog2(N_SRC)-1:0] last_grant,
   input  logic                     prio0,
   output logic [N_SRC-1:0]         gnt
);

   localparam int IDX_W = $clog2(N_SRC);

   logic [N_SRC-1:0] req_m;
   logic             found;
   int               idx;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path can leave one holding its old value (no latch).
      gnt   = '0;
      found = 1'b0;
      req_m = req;
      idx   = 0;
      if (prio0) begin
         if (req[0]) begin
            gnt[0] = 1'b1;
            found  = 1'b1;
         end
         req_m[0] = 1'b0;
      end
      for (int k = 1; k <= N_SRC; k++) begin
         idx = int'(last_grant) + k;
         if (idx >= N_SRC) idx = idx - N_SRC;
         if (!found && req_m[IDX_W'(idx)]) begin
            gnt[IDX_W'(idx)] = 1'b1;
            found            = 1'b1;
         end
      end
   end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter onto the single MAC TX stream, with length guard and counters.
// Build option: define ETH_TX_ARB_PRIORITY_EN to give source 0 strict priority.
module eth_tx_arbiter
   import eth_tx_arb_pkg::*;
#(
   parameter int N_SRC     = 2,
   parameter int MAX_BEATS = MAX_BEATS_DEF,
   parameter int CNT_W     = 32
) (
   input  logic                         clk156,
   input  logic                         aresetn,
   input  logic [N_SRC-1:0]             s_axis_tvalid,
   output logic [N_SRC-1:0]             s_axis_tready,
   input  logic [N_SRC*AXIS_DATA_W-1:0] s_axis_tdata,
   input  logic [N_SRC*AXIS_KEEP_W-1:0] s_axis_tkeep,
   input  logic [N_SRC-1:0]             s_axis_tlast,
   input  logic [N_SRC-1:0]             s_axis_tuser,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic [AXIS_DATA_W-1:0]       m_axis_tdata,
   output logic [AXIS_KEEP_W-1:0]       m_axis_tkeep,
   output logic                         m_axis_tlast,
   output logic                         m_axis_tuser,
   output logic [N_SRC-1:0]             grant,
   output logic [N_SRC*CNT_W-1:0]       pkt_count,
   output logic [CNT_W-1:0]             trunc_count
);

   localparam int IDX_W  = $clog2(N_SRC);
   localparam int BEAT_W = $clog2(MAX_BEATS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

`ifdef ETH_TX_ARB_PRIORITY_EN
   localparam logic PRIO0 = 1'b1;
`else
   localparam logic PRIO0 = 1'b0;
`endif

   arb_state_t             state_q, state_d;
   logic [N_SRC-1:0]       grant_q, pick;
   logic [IDX_W-1:0]       last_grant_q, g_idx;
   logic [BEAT_W-1:0]      beat_cnt_q;
   logic [CNT_W-1:0]       pkt_cnt_q [N_SRC];
   logic [CNT_W-1:0]       trunc_cnt_q;

   logic                   sel_valid, sel_last, sel_user;
   logic [AXIS_DATA_W-1:0] sel_data;
   logic [AXIS_KEEP_W-1:0] sel_keep;
   logic                   m_hs, at_limit;

   rr_pick #(.N_SRC(N_SRC)) u_rr_pick (
      .req        (s_axis_tvalid),
      .last_grant (last_grant_q),
      .prio0      (PRIO0),
      .gnt        (pick)
   );

   // Source selected by the one-hot grant; payload passes through with no register stage.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_user  = 1'b0;
      sel_data  = '0;
      sel_keep  = '0;
      g_idx     = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant_q[i]) begin
            sel_valid = s_axis_tvalid[i];
            sel_last  = s_axis_tlast[i];
            sel_user  = s_axis_tuser[i];
            sel_data  = s_axis_tdata[i*AXIS_DATA_W +: AXIS_DATA_W];
            sel_keep  = s_axis_tkeep[i*AXIS_KEEP_W +: AXIS_KEEP_W];
            g_idx     = IDX_W'(i);
         end
      end
   end

   assign at_limit = (beat_cnt_q == LAST_BEAT);
   assign m_hs     = (state_q == PASS) && sel_valid && m_axis_tready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|s_axis_tvalid) state_d = PASS;
         PASS:    if (m_hs && (sel_last || at_limit)) state_d = sel_last ? IDLE : DRAIN;
         DRAIN:   if (sel_valid && sel_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;
      s_axis_tready = '0;
      case (state_q)
         PASS: begin
            m_axis_tvalid = sel_valid;
            m_axis_tdata  = sel_data;
            m_axis_tkeep  = sel_keep;
            // The guard beat is closed and flagged as errored so the MAC aborts the frame.
            m_axis_tlast  = sel_last | at_limit;
            m_axis_tuser  = sel_user | at_limit;
            s_axis_tready = grant_q & {N_SRC{m_axis_tready}};
         end
         DRAIN:   s_axis_tready = grant_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk156 or negedge aresetn) begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      if (!aresetn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk156 or negedge aresetn) begin
      if (!aresetn) begin
         grant_q      <= '0;
         last_grant_q <= IDX_W'(N_SRC - 1);
         beat_cnt_q   <= '0;
         trunc_cnt_q  <= '0;
         // NOTE: the counter array is plain flops, not a RAM, so it takes the reset like any register.
         for (int i = 0; i < N_SRC; i++) pkt_cnt_q[i] <= '0;
      end else begin
         case (state_q)
            IDLE: if (|s_axis_tvalid) begin
               grant_q    <= pick;
               beat_cnt_q <= '0;
            end
            PASS: if (m_hs) begin
               beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
               if (sel_last) begin
                  pkt_cnt_q[g_idx] <= pkt_cnt_q[g_idx] + CNT_W'(1);
                  last_grant_q     <= g_idx;
                  grant_q          <= '0;
               end else if (at_limit) begin
                  trunc_cnt_q <= trunc_cnt_q + CNT_W'(1);
               end
            end
            DRAIN: if (sel_valid && sel_last) grant_q <= '0;
            default: ;
         endcase
      end
   end

   assign grant       = grant_q;
   assign trunc_count = trunc_cnt_q;

   for (genvar i = 0; i < N_SRC; i++) begin : g_cnt
      assign pkt_count[i*CNT_W +: CNT_W] = pkt_cnt_q[i];
   end

endmodule
